// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down event/timebase counter.
// The count range is 0..MODULUS-1 and a step can be prescaled by PRESCALE
// enabled cycles. At either end of the range the counter wraps, or holds
// when SATURATE is set. It also provides a parallel load, a registered
// terminal-count pulse and a sticky overflow flag.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  // The prescaler keeps at least one bit, so PRESCALE=1 still gives a legal vector.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PSC_TOP = PW'(PRESCALE - 1);

  logic [PW-1:0]    psc;
  logic [PW-1:0]    psc_next;
  logic [WIDTH-1:0] cnt_next;
  logic             tc_next;
  logic             ovf_next;
  logic [WIDTH-1:0] load_clamped;

  // Clamp out-of-range load values to the top of the count range.
  always_comb begin
    load_clamped = load_val;
    if (load_val > MAXV) begin
      load_clamped = MAXV;
    end
  end

  // Next-state logic. Load beats a step. A boundary sets ovf after clr_ovf, so a set wins over a clear.
  always_comb begin
    cnt_next = cnt;
    psc_next = psc;
    tc_next  = 1'b0;
    ovf_next = ovf;
    if (clr_ovf) begin
      ovf_next = 1'b0;
    end
    if (load) begin
      cnt_next = load_clamped;
      psc_next = '0;
    end else if (en) begin
      if (psc == PSC_TOP) begin
        psc_next = '0;
        if (up_dn) begin
          if (cnt == MAXV) begin
            tc_next  = 1'b1;
            ovf_next = 1'b1;
            cnt_next = (SATURATE != 0) ? MAXV : '0;
          end else begin
            cnt_next = cnt + WIDTH'(1);
          end
        end else begin
          if (cnt == '0) begin
            tc_next  = 1'b1;
            ovf_next = 1'b1;
            cnt_next = (SATURATE != 0) ? '0 : MAXV;
          end else begin
            cnt_next = cnt - WIDTH'(1);
          end
        end
      end else begin
        psc_next = psc + PW'(1);
      end
    end
  end

  // State register with synchronous reset; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      psc <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      psc <= psc_next;
      tc  <= tc_next;
      ovf <= ovf_next;
    end
  end

endmodule
